// File: rtl/baud_detect.sv
// Auto-baud detector: times eight bit periods of a 0x55 sync character on rxd
// and converts the measurement into a baud generator divider value.
module baud_detect #(
  parameter int unsigned CW = 16,
  parameter int unsigned TW = CW + 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          rxd,
  input  logic          arm,
  output logic          busy,
  output logic [CW-1:0] clk_div,
  output logic          div_valid,
  output logic          err
);

  localparam int unsigned QW = TW + 1;
  localparam int unsigned EW = 2;
  localparam logic [TW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HIGH,
    WAIT_EDGE,
    MEASURE,
    CALC
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] edges_q, edges_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] clk_div_q, clk_div_d;
  logic          div_valid_q, div_valid_d;
  logic          err_q, err_d;

  logic          fall;
  logic [TW-1:0] cnt_inc;
  logic [QW-1:0] sum, quot, quot_m1;
  logic          ovf;

  assign fall    = prev_q & ~sync2_q;
  assign cnt_inc = cnt_q + TW'(1);

  // Rounded count/256 for the count that will be latched on the closing edge.
  always_comb begin
    sum     = QW'(cnt_inc) + QW'(128);
    quot    = sum >> 8;
    quot_m1 = quot - QW'(1);
    ovf     = 64'(quot_m1) > ((64'd1 << CW) - 64'd1);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      edges_q     <= '0;
      busy_q      <= 1'b0;
      clk_div_q   <= '0;
      div_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q     <= rxd;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edges_q     <= edges_d;
      busy_q      <= busy_d;
      clk_div_q   <= clk_div_d;
      div_valid_q <= div_valid_d;
      err_q       <= err_d;
    end
  end

  // Results are registered on the closing edge so the pulse lands in the CALC cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edges_d     = edges_q;
    busy_d      = busy_q;
    clk_div_d   = clk_div_q;
    div_valid_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = WAIT_HIGH;
          busy_d  = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (sync2_q) state_d = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (fall) begin
          cnt_d   = '0;
          edges_d = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        cnt_d = cnt_inc;
        if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (fall && edges_q == EW'(3)) begin
          busy_d  = 1'b0;
          state_d = CALC;
          if (quot == '0 || ovf) begin
            err_d = 1'b1;
          end else begin
            div_valid_d = 1'b1;
            clk_div_d   = CW'(quot_m1);
          end
        end else if (fall) begin
          edges_d = edges_q + EW'(1);
        end
      end
      CALC: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign clk_div   = clk_div_q;
  assign div_valid = div_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_baud_detect.sv
// Directed bench for baud_detect: 0x55 sync frames at several bit periods,
// rounding/overflow limits, timeout, stalled line and mid-detection reset.
module tb_baud_detect;

  localparam int unsigned CW = 4;
  localparam int unsigned TW = 13;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          rxd;
  logic          arm;
  logic          busy;
  logic [CW-1:0] clk_div;
  logic          div_valid;
  logic          err;

  baud_detect #(.CW(CW), .TW(TW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rxd      (rxd),
    .arm      (arm),
    .busy     (busy),
    .clk_div  (clk_div),
    .div_valid(div_valid),
    .err      (err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int dv_cnt  = 0;
  int err_cnt = 0;
  int dv_cyc  = -1;
  int err_cyc = -1;
  always @(negedge sys_clk) begin
    if (div_valid === 1'b1) begin
      dv_cnt = dv_cnt + 1;
      dv_cyc = cyc;
    end
    if (err === 1'b1) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  // Drives the first nbits of an 8N1 0x55 frame; e5 is the cycle the 5th falling edge is driven.
  task automatic send(input int p, input int nbits, output int e5);
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    e5 = -1;
    for (int i = 0; i < nbits; i++) begin
      rxd = frame[i];
      if (i == 8) e5 = cyc;
      step(p);
    end
  endtask

  int d0, r0, e5, ef;

  initial begin
    sys_rst = 1'b1;
    rxd     = 1'b1;
    arm     = 1'b0;
    step(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk_div", 32'(clk_div), 32'd0);
    chk("rst_div_valid", 32'(div_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    sys_rst = 1'b0;
    step(3);

    // 320 cycles/bit: count 2560 -> q 10 -> div 9
    d0 = dv_cnt; r0 = err_cnt;
    do_arm(); step(4);
    chk("p320_busy_during", 32'(busy), 32'd1);
    send(320, 10, e5); step(5);
    chk("p320_dv_once", 32'(dv_cnt - d0), 32'd1);
    chk("p320_no_err", 32'(err_cnt - r0), 32'd0);
    chk("p320_clk_div", 32'(clk_div), 32'd9);
    chk("p320_busy_after", 32'(busy), 32'd0);
    chk("p320_latency", 32'(dv_cyc), 32'(e5 + 3));

    // 100 cycles/bit: count 800 -> q 3 -> div 2
    d0 = dv_cnt;
    do_arm(); step(4);
    send(100, 10, e5); step(5);
    chk("p100_dv_once", 32'(dv_cnt - d0), 32'd1);
    chk("p100_clk_div", 32'(clk_div), 32'd2);
    chk("p100_latency", 32'(dv_cyc), 32'(e5 + 3));

    // 8 cycles/bit: count 64 -> q 0 -> err, div held
    d0 = dv_cnt; r0 = err_cnt;
    do_arm(); step(4);
    send(8, 10, e5); step(5);
    chk("p8_err_once", 32'(err_cnt - r0), 32'd1);
    chk("p8_no_dv", 32'(dv_cnt - d0), 32'd0);
    chk("p8_clk_div_held", 32'(clk_div), 32'd2);
    chk("p8_err_latency", 32'(err_cyc), 32'(e5 + 3));
    chk("p8_busy_after", 32'(busy), 32'd0);

    // 16 cycles/bit: count 128 rounds up to q 1 -> div 0
    d0 = dv_cnt;
    do_arm(); step(4);
    send(16, 10, e5); step(5);
    chk("p16_dv_once", 32'(dv_cnt - d0), 32'd1);
    chk("p16_clk_div", 32'(clk_div), 32'd0);

    // 512 cycles/bit: count 4096 -> q 16 -> div 15, largest that fits CW=4
    d0 = dv_cnt;
    do_arm(); step(4);
    send(512, 10, e5); step(5);
    chk("p512_dv_once", 32'(dv_cnt - d0), 32'd1);
    chk("p512_clk_div", 32'(clk_div), 32'd15);

    // 528 cycles/bit: count 4224 -> q 17 -> div 16 overflows -> err
    d0 = dv_cnt; r0 = err_cnt;
    do_arm(); step(4);
    send(528, 10, e5); step(5);
    chk("p528_err_once", 32'(err_cnt - r0), 32'd1);
    chk("p528_no_dv", 32'(dv_cnt - d0), 32'd0);
    chk("p528_clk_div_held", 32'(clk_div), 32'd15);

    // Single falling edge then idle: timeout after 2^13-1 counting cycles
    d0 = dv_cnt; r0 = err_cnt;
    do_arm(); step(4);
    rxd = 1'b0; ef = cyc;
    step(4);
    rxd = 1'b1;
    step(8200);
    chk("tmo_err_once", 32'(err_cnt - r0), 32'd1);
    chk("tmo_err_cycle", 32'(err_cyc), 32'(ef + 8195));
    chk("tmo_busy_after", 32'(busy), 32'd0);
    chk("tmo_no_dv", 32'(dv_cnt - d0), 32'd0);
    chk("tmo_clk_div_held", 32'(clk_div), 32'd15);

    // Line held low before arm: stall busy, then a normal detection
    d0 = dv_cnt; r0 = err_cnt;
    rxd = 1'b0; step(5);
    do_arm(); step(20);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_no_result", 32'(dv_cnt - d0 + err_cnt - r0), 32'd0);
    rxd = 1'b1; step(5);
    send(320, 10, e5); step(5);
    chk("stall_dv_once", 32'(dv_cnt - d0), 32'd1);
    chk("stall_clk_div", 32'(clk_div), 32'd9);
    chk("stall_busy_after", 32'(busy), 32'd0);

    // Reset after the 3rd edge abandons the detection silently
    d0 = dv_cnt; r0 = err_cnt;
    do_arm(); step(4);
    send(320, 5, e5);
    sys_rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_clk_div", 32'(clk_div), 32'd0);
    chk("arst_div_valid", 32'(div_valid), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    step(2);
    sys_rst = 1'b0;
    rxd = 1'b1;
    step(5);
    send(320, 10, e5); step(5);
    chk("arst_no_err", 32'(err_cnt - r0), 32'd0);
    chk("arst_needs_arm", 32'(dv_cnt - d0), 32'd0);
    chk("arst_busy_idle", 32'(busy), 32'd0);
    do_arm(); step(4);
    send(320, 10, e5); step(5);
    chk("rearm_dv_once", 32'(dv_cnt - d0), 32'd1);
    chk("rearm_clk_div", 32'(clk_div), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
